// File: rtl/ex_demux_pkg.sv
// ---------------------------------------------------------------------------
// ex_demux_pkg
// Shared types and constants for the EX-stage result demultiplexer.
//   - default widths for data, channel count, select and drop counter
//   - named destination select codes (sel 0 and 1 both address ch0)
//   - channel buffer state encoding
//   - sel_to_ch(): maps a select code onto {valid, channel index}
// ---------------------------------------------------------------------------
package ex_demux_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NUM_CH = 10;
  localparam int DEF_SEL_W  = 4;
  localparam int DEF_CNT_W  = 16;
  localparam int CH_IDX_W   = 4;

  // Destination select codes. Codes 11..15 have no destination.
  localparam logic [3:0] SEL_CH0       = 4'd0;
  localparam logic [3:0] SEL_CH0_ALT   = 4'd1;
  localparam logic [3:0] SEL_CH1       = 4'd2;
  localparam logic [3:0] SEL_CH2       = 4'd3;
  localparam logic [3:0] SEL_CH3       = 4'd4;
  localparam logic [3:0] SEL_CH4       = 4'd5;
  localparam logic [3:0] SEL_CH5       = 4'd6;
  localparam logic [3:0] SEL_CH6       = 4'd7;
  localparam logic [3:0] SEL_CH7       = 4'd8;
  localparam logic [3:0] SEL_CH8       = 4'd9;
  localparam logic [3:0] SEL_CH9       = 4'd10;
  localparam logic [3:0] SEL_MAX_VALID = 4'd10;

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } ch_state_t;

  typedef struct packed {
    logic                valid;
    logic [CH_IDX_W-1:0] idx;
  } ch_sel_t;

  // Decode a select code into {valid, channel index}.
  function automatic ch_sel_t sel_to_ch(input logic [3:0] sel);
    ch_sel_t res;
    res.valid = 1'b0;
    res.idx   = 4'd0;
    case (sel)
      SEL_CH0, SEL_CH0_ALT: begin res.valid = 1'b1; res.idx = 4'd0; end
      SEL_CH1: begin res.valid = 1'b1; res.idx = 4'd1; end
      SEL_CH2: begin res.valid = 1'b1; res.idx = 4'd2; end
      SEL_CH3: begin res.valid = 1'b1; res.idx = 4'd3; end
      SEL_CH4: begin res.valid = 1'b1; res.idx = 4'd4; end
      SEL_CH5: begin res.valid = 1'b1; res.idx = 4'd5; end
      SEL_CH6: begin res.valid = 1'b1; res.idx = 4'd6; end
      SEL_CH7: begin res.valid = 1'b1; res.idx = 4'd7; end
      SEL_CH8: begin res.valid = 1'b1; res.idx = 4'd8; end
      SEL_CH9: begin res.valid = 1'b1; res.idx = 4'd9; end
      default: begin res.valid = 1'b0; res.idx = 4'd0; end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ex_result_demux_if.sv
// ---------------------------------------------------------------------------
// ex_result_demux_if
// Bundles the producer handshake, the per-channel consumer handshakes and the
// drop status of ex_result_demux.
//   master : producer/consumer side (drives in_*, out_ready)
//   slave  : the demux itself
// Signals:
//   in_valid/in_ready/in_data/in_sel   producer handshake + destination
//   out_valid/out_ready/out_data       NUM_CH independent drain ports,
//                                      channel k at out_data[k*DATA_W +: DATA_W]
//   drop_pulse/drop_cnt                invalid-select status
// ---------------------------------------------------------------------------
interface ex_result_demux_if #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 10,
  parameter int SEL_W  = 4,
  parameter int CNT_W  = 16
);

  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_data;
  logic [SEL_W-1:0]         in_sel;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic                     drop_pulse;
  logic [CNT_W-1:0]         drop_cnt;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, drop_pulse, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, drop_pulse, drop_cnt
  );

endinterface

// File: rtl/ex_chan_buf.sv
// ---------------------------------------------------------------------------
// ex_chan_buf
// One-entry result buffer for a single demux channel.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   load_en, load_data    write strobe from the demux (only issued when the
//                         buffer is empty or draining this cycle)
//   out_ready             consumer ready
//   out_valid, out_data   registered drain port; data is held until taken
// ---------------------------------------------------------------------------
module ex_chan_buf
  import ex_demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  ch_state_t         state_r;
  ch_state_t         state_next_s;
  logic [DATA_W-1:0] data_r;

  // Buffer occupancy state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= CH_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next occupancy: a load always wins, so drain+load keeps the buffer FULL.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      CH_EMPTY: begin
        if (load_en) begin
          state_next_s = CH_FULL;
        end else begin
          state_next_s = CH_EMPTY;
        end
      end
      CH_FULL: begin
        if (load_en) begin
          state_next_s = CH_FULL;
        end else if (out_ready) begin
          state_next_s = CH_EMPTY;
        end else begin
          state_next_s = CH_FULL;
        end
      end
      default: begin
        state_next_s = CH_EMPTY;
      end
    endcase
  end

  // Payload register; only a load changes it, so it is stable while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_r <= '0;
    end else if (load_en) begin
      data_r <= load_data;
    end else begin
      data_r <= data_r;
    end
  end

  assign out_valid = (state_r == CH_FULL);
  assign out_data  = data_r;

endmodule

// File: rtl/ex_result_demux.sv
// ---------------------------------------------------------------------------
// ex_result_demux
// Registered 1:10 distributor for EX-stage results. A result accepted with a
// valid select lands in the addressed channel buffer one clock later; a
// result with an unmapped select is accepted, dropped and counted.
// Ports:
//   clk     clock
//   rst_n   synchronous active-low reset; holds in_ready low while asserted
//   bus     ex_result_demux_if.slave (producer handshake, NUM_CH drain
//           ports, drop_pulse / saturating drop_cnt)
// in_ready depends combinationally on the addressed channel's out_ready so a
// draining channel can be refilled in the same cycle.
// ---------------------------------------------------------------------------
module ex_result_demux
  import ex_demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SEL_W  = DEF_SEL_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  ex_result_demux_if.slave   bus
);

  ch_sel_t                  decode_s;
  logic                     in_ready_s;
  logic                     accept_s;
  logic                     drop_s;
  logic [NUM_CH-1:0]        out_valid_s;
  logic [NUM_CH*DATA_W-1:0] out_data_s;
  logic                     drop_pulse_r;
  logic [CNT_W-1:0]         drop_cnt_r;

  assign decode_s = sel_to_ch(bus.in_sel);

  // Producer ready: unmapped selects are always taken; mapped ones need room.
  always_comb begin
    in_ready_s = 1'b0;
    if (!rst_n) begin
      in_ready_s = 1'b0;
    end else if (decode_s.valid) begin
      in_ready_s = !out_valid_s[decode_s.idx] | bus.out_ready[decode_s.idx];
    end else begin
      in_ready_s = 1'b1;
    end
  end

  assign accept_s = bus.in_valid & in_ready_s;
  assign drop_s   = accept_s & !decode_s.valid;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic load_s;

    assign load_s = accept_s & decode_s.valid &
                    (decode_s.idx == CH_IDX_W'(k));

    ex_chan_buf #(
      .DATA_W (DATA_W)
    ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_en   (load_s),
      .load_data (bus.in_data),
      .out_ready (bus.out_ready[k]),
      .out_valid (out_valid_s[k]),
      .out_data  (out_data_s[k*DATA_W +: DATA_W])
    );
  end

  // Drop status: one-cycle pulse and a counter that sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_pulse_r <= 1'b0;
      drop_cnt_r   <= '0;
    end else begin
      drop_pulse_r <= drop_s;
      if (drop_s && (drop_cnt_r != {CNT_W{1'b1}})) begin
        drop_cnt_r <= drop_cnt_r + CNT_W'(1);
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_s;
  assign bus.out_data   = out_data_s;
  assign bus.drop_pulse = drop_pulse_r;
  assign bus.drop_cnt   = drop_cnt_r;

endmodule

// File: tb/tb_ex_result_demux.sv
// ---------------------------------------------------------------------------
// tb_ex_result_demux
// Directed scenarios followed by random traffic, compared every cycle against
// a behavioural model of the ten channel buffers and the drop counter. A
// second instance with a 2-bit drop counter shares the same stimulus.
// ---------------------------------------------------------------------------
module tb_ex_result_demux;

  localparam int NCH = 10;

  logic clk;
  logic rst_n;

  ex_result_demux_if #(.DATA_W(32), .NUM_CH(NCH), .SEL_W(4), .CNT_W(16)) ifa ();
  ex_result_demux_if #(.DATA_W(32), .NUM_CH(NCH), .SEL_W(4), .CNT_W(2))  ifb ();

  ex_result_demux #(.DATA_W(32), .NUM_CH(NCH), .SEL_W(4), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  ex_result_demux #(.DATA_W(32), .NUM_CH(NCH), .SEL_W(4), .CNT_W(2)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  assign ifb.in_valid  = ifa.in_valid;
  assign ifb.in_sel    = ifa.in_sel;
  assign ifb.in_data   = ifa.in_data;
  assign ifb.out_ready = ifa.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  bit          m_full [NCH];
  logic [31:0] m_data [NCH];
  int          m_drops;
  bit          m_pulse;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Destination channel for a select code, -1 when it has none.
  function automatic int dest_of(input logic [3:0] sel);
    int s;
    s = int'(sel);
    if (s <= 1) return 0;
    else if (s <= 10) return s - 1;
    else return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_full[k] = 1'b0;
      m_data[k] = 32'd0;
    end
    m_drops = 0;
    m_pulse = 1'b0;
  endtask

  task automatic check_outputs();
    logic [NCH-1:0] exp_valid;
    for (int k = 0; k < NCH; k++) exp_valid[k] = m_full[k];
    check_val("out_valid", 64'(ifa.out_valid), 64'(exp_valid));
    for (int k = 0; k < NCH; k++)
      check_val($sformatf("out_data[%0d]", k), 64'(ifa.out_data[k*32 +: 32]), 64'(m_data[k]));
    check_val("drop_pulse", 64'(ifa.drop_pulse), 64'(m_pulse));
    check_val("drop_cnt", 64'(ifa.drop_cnt), 64'(m_drops));
    check_val("drop_cnt_sat", 64'(ifb.drop_cnt), 64'((m_drops > 3) ? 3 : m_drops));
  endtask

  // One clock of stimulus: drive, check in_ready, clock, update model, check.
  task automatic step(input bit rst, input bit v, input logic [3:0] sel,
                      input logic [31:0] d, input logic [NCH-1:0] rdy);
    int ch;
    bit exp_rdy;
    bit acc;
    rst_n         = rst;
    ifa.in_valid  = v;
    ifa.in_sel    = sel;
    ifa.in_data   = d;
    ifa.out_ready = rdy;
    #1;
    ch = dest_of(sel);
    if (!rst) exp_rdy = 1'b0;
    else if (ch < 0) exp_rdy = 1'b1;
    else exp_rdy = !m_full[ch] || rdy[ch];
    check_val("in_ready", 64'(ifa.in_ready), 64'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clk);
    #1;
    if (!rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < NCH; k++)
        if (m_full[k] && rdy[k]) m_full[k] = 1'b0;
      m_pulse = 1'b0;
      if (acc) begin
        if (ch >= 0) begin
          m_full[ch] = 1'b1;
          m_data[ch] = d;
        end else begin
          m_pulse = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
      end
    end
    check_outputs();
  endtask

  localparam logic [NCH-1:0] ALL_RDY = {NCH{1'b1}};
  localparam logic [NCH-1:0] NO_RDY  = {NCH{1'b0}};

  initial begin
    rst_n         = 1'b0;
    ifa.in_valid  = 1'b0;
    ifa.in_sel    = 4'd0;
    ifa.in_data   = 32'd0;
    ifa.out_ready = NO_RDY;
    model_reset();

    // Reset
    step(1'b0, 1'b0, 4'd0, 32'd0, NO_RDY);
    step(1'b0, 1'b1, 4'd3, 32'h1111_1111, NO_RDY);

    // sel 0 and sel 1 both reach ch0
    step(1'b1, 1'b1, 4'd0, 32'hA5A5_0001, ALL_RDY);
    step(1'b1, 1'b1, 4'd1, 32'hA5A5_0002, ALL_RDY);
    step(1'b1, 1'b0, 4'd0, 32'd0, ALL_RDY);

    // ch9 stalled: held data, blocked same-channel producer, other channel free
    step(1'b1, 1'b1, 4'd10, 32'hDEAD_BEEF, 10'h1FF);
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b1, 4'd10, 32'hBAD0_0000 + 32'(i), 10'h1FF);
    step(1'b1, 1'b1, 4'd2, 32'h0000_0022, 10'h1FD);
    step(1'b1, 1'b0, 4'd0, 32'd0, ALL_RDY);

    // ch3 drain and load in the same cycle
    step(1'b1, 1'b1, 4'd4, 32'h0000_5555, NO_RDY);
    step(1'b1, 1'b1, 4'd4, 32'h0000_1234, 10'h008);
    step(1'b1, 1'b0, 4'd0, 32'd0, NO_RDY);

    // Unmapped selects are dropped and counted; the 2-bit counter saturates
    for (int s = 11; s <= 15; s++)
      step(1'b1, 1'b1, 4'(s), 32'hC0DE_0000 + 32'(s), NO_RDY);
    check_val("drop_cnt_after_5", 64'(ifa.drop_cnt), 64'd5);
    step(1'b1, 1'b1, 4'd15, 32'hC0DE_00FF, NO_RDY);
    check_val("drop_cnt_sat_after_6", 64'(ifb.drop_cnt), 64'd3);

    // Fill every channel, then reset mid-operation
    step(1'b1, 1'b1, 4'd0, 32'hF000_0000, NO_RDY);
    for (int s = 2; s <= 10; s++)
      step(1'b1, 1'b1, 4'(s), 32'hF000_0000 + 32'(s), NO_RDY);
    check_val("all_full", 64'(ifa.out_valid), 64'(10'h3FF));
    step(1'b0, 1'b1, 4'd0, 32'h1, NO_RDY);
    step(1'b1, 1'b0, 4'd0, 32'h0, NO_RDY);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)), $urandom, NCH'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
